// File: rtl/ring_alu_pkg.sv
// Shared opcode map, flag bundle and ring reduction helper
// for the pipelined ring ALU.
package ring_alu_pkg;

    localparam logic [3:0] OP_NOT  = 4'b0000;
    localparam logic [3:0] OP_IO   = 4'b0001;
    localparam logic [3:0] OP_EQ   = 4'b0010;
    localparam logic [3:0] OP_NE   = 4'b0011;
    localparam logic [3:0] OP_GT   = 4'b0100;
    localparam logic [3:0] OP_GE   = 4'b0101;
    localparam logic [3:0] OP_LT   = 4'b0110;
    localparam logic [3:0] OP_LE   = 4'b0111;
    localparam logic [3:0] OP_INC  = 4'b1000;
    localparam logic [3:0] OP_DEC  = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_AND  = 4'b1110;
    localparam logic [3:0] OP_OR   = 4'b1111;

    typedef struct packed {
        logic baf;
        logic iof;
        logic zf;
    } flags_t;

    // One conditional subtraction, not a true modulo
    function automatic logic [31:0] ring_reduce(
        input logic [31:0] v,
        input logic [31:0] m
    );
        return (v >= m) ? v - m : v;
    endfunction

endpackage

// File: rtl/ring_alu_core.sv
// Combinational op and flag evaluation for the ring ALU.
// Produces raw and ring-reduced results plus the flag bundle.
module ring_alu_core
    import ring_alu_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int RING_MOD = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] xe,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z_raw,
    output logic [WIDTH-1:0] z,
    output flags_t           flags
);

    localparam logic [WIDTH-1:0] MOD = WIDTH'(RING_MOD);

    always_comb begin
        z_raw = '0;
        unique case (op)
            OP_NOT:  z_raw = ~xe;
            OP_IO:   z_raw = '0;
            OP_EQ:   z_raw[0] = (xe == y);
            OP_NE:   z_raw[0] = (xe != y);
            OP_GT:   z_raw[0] = (xe > y);
            OP_GE:   z_raw[0] = (xe >= y);
            OP_LT:   z_raw[0] = (xe < y);
            OP_LE:   z_raw[0] = (xe <= y);
            OP_INC:  z_raw = xe + 1'b1;
            OP_DEC:  z_raw = xe - 1'b1;
            OP_ADD:  z_raw = xe + y;
            OP_SUB:  z_raw = xe - y;
            OP_NAND: z_raw = ~xe | ~y;
            OP_XOR:  z_raw = xe ^ y;
            OP_AND:  z_raw = xe & y;
            OP_OR:   z_raw = xe | y;
            default: z_raw = '0;
        endcase
    end

    assign z = WIDTH'(ring_reduce(32'(z_raw), 32'(RING_MOD)));

    always_comb begin
        flags.baf = (xe >= MOD) || (y >= MOD);
        flags.iof = (op == OP_IO);
        flags.zf  = (z_raw == '0);
    end

endmodule

// File: rtl/ring_alu_pipe.sv
// Registered, handshaked ring ALU with accumulator operand
// and sticky flag accumulation.
module ring_alu_pipe
    import ring_alu_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int RING_MOD = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             use_acc,
    input  logic             acc_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_raw,
    output logic             baf,
    output logic             iof,
    output logic             zf,
    output logic             sticky_baf,
    output logic             sticky_zf,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] xe;
    logic [WIDTH-1:0] zr_n;
    logic [WIDTH-1:0] z_n;
    flags_t           f_n;
    flags_t           f_q;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xe       = use_acc ? acc : x;

    ring_alu_core #(
        .WIDTH    (WIDTH),
        .RING_MOD (RING_MOD)
    ) u_core (
        .op    (op),
        .xe    (xe),
        .y     (y),
        .z_raw (zr_n),
        .z     (z_n),
        .flags (f_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            z          <= '0;
            z_raw      <= '0;
            f_q        <= '0;
            sticky_baf <= 1'b0;
            sticky_zf  <= 1'b0;
            acc        <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                z         <= z_n;
                z_raw     <= zr_n;
                f_q       <= f_n;
                if (acc_we)
                    acc <= z_n;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear first, then fold in the op accepted this cycle
            if (flag_clr) begin
                sticky_baf <= accept && f_n.baf;
                sticky_zf  <= accept && f_n.zf;
            end else if (accept) begin
                sticky_baf <= sticky_baf | f_n.baf;
                sticky_zf  <= sticky_zf | f_n.zf;
            end
        end
    end

    assign baf = f_q.baf;
    assign iof = f_q.iof;
    assign zf  = f_q.zf;

endmodule

// File: tb/tb_ring_alu_pipe.sv
// Self-checking bench for ring_alu_pipe against an arithmetic
// reference model, plus a WIDTH=8 / RING_MOD=200 instance.
module tb_ring_alu_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic [5:0] x = 6'd0;
    logic [5:0] y = 6'd0;
    logic       use_acc = 1'b0;
    logic       acc_we = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] z;
    logic [5:0] z_raw;
    logic       baf, iof, zf;
    logic       sticky_baf, sticky_zf;
    logic       flag_clr = 1'b0;
    logic [5:0] acc;

    logic       w_in_valid = 1'b0;
    logic       w_in_ready;
    logic [3:0] w_op = 4'd0;
    logic [7:0] w_x = 8'd0;
    logic [7:0] w_y = 8'd0;
    logic       w_out_valid;
    logic [7:0] w_z, w_z_raw, w_acc;
    logic       w_baf, w_iof, w_zf, w_sb, w_sz;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_valid, m_acc, m_z, m_zr, m_baf, m_iof, m_zf, m_sb, m_sz;

    always #5 clk = ~clk;

    ring_alu_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x(x), .y(y), .use_acc(use_acc), .acc_we(acc_we),
        .out_valid(out_valid), .out_ready(out_ready), .z(z),
        .z_raw(z_raw), .baf(baf), .iof(iof), .zf(zf),
        .sticky_baf(sticky_baf), .sticky_zf(sticky_zf),
        .flag_clr(flag_clr), .acc(acc)
    );

    ring_alu_pipe #(.WIDTH(8), .RING_MOD(200)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .op(w_op), .x(w_x), .y(w_y),
        .use_acc(1'b0), .acc_we(1'b0), .out_valid(w_out_valid),
        .out_ready(1'b1), .z(w_z), .z_raw(w_z_raw), .baf(w_baf),
        .iof(w_iof), .zf(w_zf), .sticky_baf(w_sb), .sticky_zf(w_sz),
        .flag_clr(1'b0), .acc(w_acc)
    );

    function automatic int ref_raw(int o, int a, int b);
        int m;
        m = 64;
        case (o)
            0:  return m - 1 - a;
            1:  return 0;
            2:  return (a == b) ? 1 : 0;
            3:  return (a != b) ? 1 : 0;
            4:  return (a > b) ? 1 : 0;
            5:  return (a >= b) ? 1 : 0;
            6:  return (a < b) ? 1 : 0;
            7:  return (a <= b) ? 1 : 0;
            8:  return (a + 1) % m;
            9:  return (a - 1 + m) % m;
            10: return (a + b) % m;
            11: return (a - b + m) % m;
            12: return m - 1 - (a & b);
            13: return a ^ b;
            14: return a & b;
            default: return a | b;
        endcase
    endfunction

    // Advance one clock with the current inputs, updating the model
    task automatic cycle();
        int acc_ok, xe, r, rz;
        acc_ok = (in_valid && (!m_valid || out_ready)) ? 1 : 0;
        if (acc_ok != 0) begin
            xe = use_acc ? m_acc : int'(x);
            r  = ref_raw(int'(op), xe, int'(y));
            rz = (r >= 32) ? r - 32 : r;
            m_valid = 1;
            m_zr = r;
            m_z = rz;
            m_baf = (xe >= 32 || int'(y) >= 32) ? 1 : 0;
            m_iof = (op == 4'd1) ? 1 : 0;
            m_zf = (r == 0) ? 1 : 0;
            if (acc_we) m_acc = rz;
            if (flag_clr) begin
                m_sb = m_baf;
                m_sz = m_zf;
            end else begin
                m_sb = m_sb | m_baf;
                m_sz = m_sz | m_zf;
            end
        end else begin
            if (out_ready) m_valid = 0;
            if (flag_clr) begin
                m_sb = 0;
                m_sz = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 0; m_acc = 0; m_z = 0; m_zr = 0;
        m_baf = 0; m_iof = 0; m_zf = 0; m_sb = 0; m_sz = 0;
    endtask

    task automatic apply_reset();
        in_valid = 0; out_ready = 1; flag_clr = 0;
        use_acc = 0; acc_we = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic set_op(int o, int a, int b, bit ua, bit aw);
        in_valid = 1;
        op = 4'(o);
        x = 6'(a);
        y = 6'(b);
        use_acc = ua;
        acc_we = aw;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({out_valid, z, z_raw, baf, iof, zf} !== 15'd0) begin
            errors++;
            $display("FAIL reset_out got %b %0d %0d %b%b%b want 0",
                     out_valid, z, z_raw, baf, iof, zf);
        end
        checks++;
        if ({sticky_baf, sticky_zf, acc} !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got sb=%b sz=%b acc=%0d rdy=%b",
                     sticky_baf, sticky_zf, acc, in_ready);
        end
    endtask

    task automatic test_arith();
        set_op(10, 20, 15, 0, 0);
        cycle();
        checks++;
        if (out_valid !== 1'b1 || z_raw !== 6'd35 || z !== 6'd3 ||
            baf !== 1'b0 || zf !== 1'b0) begin
            errors++;
            $display("FAIL add_20_15 got v=%b zr=%0d z=%0d baf=%b zf=%b want 1 35 3 0 0",
                     out_valid, z_raw, z, baf, zf);
        end
        set_op(11, 3, 5, 0, 0);
        cycle();
        checks++;
        if (z_raw !== 6'd62 || z !== 6'd30) begin
            errors++;
            $display("FAIL sub_wrap got zr=%0d z=%0d want 62 30", z_raw, z);
        end
        set_op(10, 40, 1, 0, 0);
        cycle();
        checks++;
        if (baf !== 1'b1 || sticky_baf !== 1'b1 || z !== 6'd9) begin
            errors++;
            $display("FAIL baf_40 got baf=%b sb=%b z=%0d want 1 1 9",
                     baf, sticky_baf, z);
        end
        set_op(10, 1, 2, 0, 0);
        flag_clr = 1;
        cycle();
        flag_clr = 0;
        checks++;
        if (sticky_baf !== 1'b0 || z !== 6'd3) begin
            errors++;
            $display("FAIL clr_with_op got sb=%b z=%0d want 0 3",
                     sticky_baf, z);
        end
        in_valid = 0;
        cycle();
    endtask

    task automatic test_acc_chain();
        int want;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            set_op(10, 0, 10, 1, 1);
            cycle();
            want = (10 * i) % 64;
            want = (want >= 32) ? want - 32 : want;
            checks++;
            if (acc !== 6'(want) || z !== 6'(want)) begin
                errors++;
                $display("FAIL acc_step%0d got acc=%0d z=%0d want %0d",
                         i, acc, z, want);
            end
        end
        in_valid = 0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [5:0] hz;
        logic [5:0] hacc;
        set_op(10, 4, 5, 0, 1);
        out_ready = 0;
        cycle();
        hz = z;
        hacc = acc;
        checks++;
        if (hz !== 6'd9 || hacc !== 6'd9) begin
            errors++;
            $display("FAIL bp_first got z=%0d acc=%0d want 9 9", hz, hacc);
        end
        set_op(10, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready%0d got %b want 0", i, in_ready);
            end
            cycle();
            checks++;
            if (z !== 6'd9 || acc !== 6'd9 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got z=%0d acc=%0d v=%b want 9 9 1",
                         i, z, acc, out_valid);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got %b want 1", in_ready);
        end
        cycle();
        checks++;
        if (z !== 6'd2 || acc !== 6'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_next got z=%0d acc=%0d v=%b want 2 2 1",
                     z, acc, out_valid);
        end
        in_valid = 0;
        cycle();
    endtask

    task automatic test_io_not();
        set_op(1, 7, 7, 0, 0);
        cycle();
        checks++;
        if (z !== 6'd0 || iof !== 1'b1 || zf !== 1'b1 || sticky_zf !== 1'b1) begin
            errors++;
            $display("FAIL op_io got z=%0d iof=%b zf=%b sz=%b want 0 1 1 1",
                     z, iof, zf, sticky_zf);
        end
        set_op(0, 63, 0, 0, 0);
        cycle();
        checks++;
        if (z_raw !== 6'd0 || zf !== 1'b1 || iof !== 1'b0) begin
            errors++;
            $display("FAIL op_not63 got zr=%0d zf=%b iof=%b want 0 1 0",
                     z_raw, zf, iof);
        end
        in_valid = 0;
        cycle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_op(10, 10, 7, 0, 1);
        out_ready = 0;
        cycle();
        in_valid = 0;
        checks++;
        if (acc !== 6'd17 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst got acc=%0d v=%b want 17 1", acc, out_valid);
        end
        #1;
        rst = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc !== 6'd0 ||
            sticky_baf !== 1'b0 || sticky_zf !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got v=%b acc=%0d sb=%b sz=%b want 0",
                     out_valid, acc, sticky_baf, sticky_zf);
        end
        @(posedge clk);
        #1;
        rst = 0;
        out_ready = 1;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flag_clr  = ($urandom_range(0, 15) == 0);
            op        = 4'($urandom_range(0, 15));
            x         = 6'($urandom_range(0, 63));
            y         = 6'($urandom_range(0, 63));
            use_acc   = 1'($urandom_range(0, 1));
            acc_we    = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (in_ready !== 1'((!m_valid) || out_ready)) begin
                errors++;
                $display("FAIL rnd_ready%0d got %b", i, in_ready);
            end
            cycle();
            checks++;
            if (out_valid !== 1'(m_valid) || z !== 6'(m_z) ||
                z_raw !== 6'(m_zr) || acc !== 6'(m_acc)) begin
                errors++;
                $display("FAIL rnd_data%0d got v=%b z=%0d zr=%0d acc=%0d want %0d %0d %0d %0d",
                         i, out_valid, z, z_raw, acc, m_valid, m_z, m_zr, m_acc);
            end
            checks++;
            if ({baf, iof, zf, sticky_baf, sticky_zf} !==
                {1'(m_baf), 1'(m_iof), 1'(m_zf), 1'(m_sb), 1'(m_sz)}) begin
                errors++;
                $display("FAIL rnd_flags%0d got %b%b%b%b%b want %0d%0d%0d%0d%0d",
                         i, baf, iof, zf, sticky_baf, sticky_zf,
                         m_baf, m_iof, m_zf, m_sb, m_sz);
            end
        end
        in_valid = 0;
        flag_clr = 0;
        out_ready = 1;
        cycle();
    endtask

    task automatic test_wide();
        w_in_valid = 1;
        w_op = 4'd10;
        w_x = 8'd150;
        w_y = 8'd100;
        @(posedge clk);
        #1;
        w_in_valid = 0;
        checks++;
        if (w_z_raw !== 8'd250 || w_z !== 8'd50 || w_baf !== 1'b0 ||
            w_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wide_add got zr=%0d z=%0d baf=%b v=%b want 250 50 0 1",
                     w_z_raw, w_z, w_baf, w_out_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arith();
        test_acc_chain();
        test_backpressure();
        test_io_not();
        test_async_reset();
        test_random();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
